// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu
//  Description : EX-stage ALU with registered, handshaked results and an
//                iterative (one bit per cycle) multiply/divide unit that
//                owns the architectural HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam logic [4:0] c_OP_AND   = 5'd0;
    localparam logic [4:0] c_OP_OR    = 5'd1;
    localparam logic [4:0] c_OP_ADD   = 5'd2;
    localparam logic [4:0] c_OP_XOR   = 5'd3;
    localparam logic [4:0] c_OP_SLL   = 5'd4;
    localparam logic [4:0] c_OP_SRL   = 5'd5;
    localparam logic [4:0] c_OP_SUB   = 5'd6;
    localparam logic [4:0] c_OP_SLTU  = 5'd7;
    localparam logic [4:0] c_OP_SLT   = 5'd8;
    localparam logic [4:0] c_OP_SRA   = 5'd9;
    localparam logic [4:0] c_OP_LUI   = 5'd10;
    localparam logic [4:0] c_OP_NOR   = 5'd12;
    localparam logic [4:0] c_OP_MULT  = 5'd13;
    localparam logic [4:0] c_OP_MULTU = 5'd14;
    localparam logic [4:0] c_OP_DIV   = 5'd15;
    localparam logic [4:0] c_OP_DIVU  = 5'd16;
    localparam logic [4:0] c_OP_MFHI  = 5'd17;
    localparam logic [4:0] c_OP_MFLO  = 5'd18;
    localparam logic [4:0] c_OP_MTHI  = 5'd19;
    localparam logic [4:0] c_OP_MTLO  = 5'd20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    // Iteration datapath: acc_hi/acc_lo form the double-width product
    // (multiply) or partial remainder / dividend-quotient pair (divide).
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_mcand;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_a;         // original dividend, needed for divide-by-zero HI
    logic               r_neg_q;     // negate product / quotient at the end
    logic               r_neg_r;     // negate remainder at the end
    logic               r_div0;
    logic [SHW-1:0]     r_cnt;

    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_res_single;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [2*WIDTH-1:0] w_mul_final;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_quo_final;
    logic [WIDTH-1:0]   w_rem_final;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
    assign result    = r_result;
    assign zero      = r_zero;
    assign hi        = r_hi;
    assign lo        = r_lo;

    // Operand magnitudes for the signed mul/div variants
    assign w_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the whole double-width accumulator right by one.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_prod  = {w_mul_sum, r_acc_lo[WIDTH-1:1]};
    assign w_mul_final = r_neg_q ? (~w_mul_prod + 1'b1) : w_mul_prod;

    // Restoring step: shift in the next dividend bit, subtract the divisor and
    // keep the difference only when it did not go negative. The remainder is
    // always below the divisor, so the MSB of the difference is the borrow.
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mcand};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_quo   = {r_acc_lo[WIDTH-2:0], w_div_ge};
    assign w_quo_final = r_neg_q ? (~w_div_quo + 1'b1) : w_div_quo;
    assign w_rem_final = r_neg_r ? (~w_div_rem + 1'b1) : w_div_rem;

    // Single-cycle operation results
    always_comb begin
        w_res_single = '0;
        case (op)
            c_OP_AND:  w_res_single = a & b;
            c_OP_OR:   w_res_single = a | b;
            c_OP_ADD:  w_res_single = a + b;
            c_OP_XOR:  w_res_single = a ^ b;
            c_OP_SLL:  w_res_single = b << a[SHW-1:0];
            c_OP_SRL:  w_res_single = b >> a[SHW-1:0];
            c_OP_SUB:  w_res_single = a - b;
            c_OP_SLTU: w_res_single = {{(WIDTH-1){1'b0}}, (a < b)};
            c_OP_SLT:  w_res_single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_SRA:  w_res_single = $signed(b) >>> a[SHW-1:0];
            c_OP_LUI:  w_res_single = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            c_OP_NOR:  w_res_single = ~(a | b);
            c_OP_MFHI: w_res_single = r_hi;
            c_OP_MFLO: w_res_single = r_lo;
            c_OP_MTHI: w_res_single = a;
            c_OP_MTLO: w_res_single = a;
            default:   w_res_single = '0;
        endcase
    end

    // Control FSM, iteration datapath and architectural result/HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_mcand  <= '0;
            r_a      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt <= '1;
                        if ((op == c_OP_MULT) || (op == c_OP_MULTU)) begin
                            r_state  <= S_MUL;
                            r_acc_hi <= '0;
                            r_acc_lo <= w_b_mag;
                            r_mcand  <= w_a_mag;
                            r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        end else if ((op == c_OP_DIV) || (op == c_OP_DIVU)) begin
                            r_state  <= S_DIV;
                            r_acc_hi <= '0;
                            r_acc_lo <= w_a_mag;
                            r_mcand  <= w_b_mag;
                            r_a      <= a;
                            r_div0   <= (b == '0);
                            r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_r  <= w_signed && a[WIDTH-1];
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_res_single;
                            r_zero   <= (w_res_single == '0);
                            if (op == c_OP_MTHI) r_hi <= a;
                            if (op == c_OP_MTLO) r_lo <= a;
                        end
                    end
                end
                S_MUL: begin
                    {r_acc_hi, r_acc_lo} <= w_mul_prod;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state  <= S_DONE;
                        r_hi     <= w_mul_final[2*WIDTH-1:WIDTH];
                        r_lo     <= w_mul_final[WIDTH-1:0];
                        r_result <= w_mul_final[WIDTH-1:0];
                        r_zero   <= (w_mul_final[WIDTH-1:0] == '0);
                    end
                end
                S_DIV: begin
                    r_acc_hi <= w_div_rem;
                    r_acc_lo <= w_div_quo;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        if (r_div0) begin
                            r_hi     <= r_a;
                            r_lo     <= '1;
                            r_result <= '1;
                            r_zero   <= 1'b0;
                        end else begin
                            r_hi     <= w_rem_final;
                            r_lo     <= w_quo_final;
                            r_result <= w_quo_final;
                            r_zero   <= (w_quo_final == '0);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mdu
//  Description : Self-checking bench for alu_mdu: directed vector table,
//                backpressure and reset-abort sequences, randomized ops
//                against an arithmetic reference model, and a 16-bit build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [4:0]  op;
    logic [31:0] a, b, result, hi, lo;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16, busy16;
    logic [4:0]  op16;
    logic [15:0] a16, b16, result16, hi16, lo16;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .hi(hi), .lo(lo), .busy(busy)
    );

    alu_mdu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .zero(zero16), .hi(hi16), .lo(lo16), .busy(busy16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the architectural definition
    function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l,
                                  output logic [31:0] r);
        longint      sx, sy, q, rm;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = 32'h0;
        case (o)
            5'd0:  r = x & y;
            5'd1:  r = x | y;
            5'd2:  r = x + y;
            5'd3:  r = x ^ y;
            5'd4:  r = y << x[4:0];
            5'd5:  r = y >> x[4:0];
            5'd6:  r = x - y;
            5'd7:  r = (x < y) ? 32'd1 : 32'd0;
            5'd8:  r = (sx < sy) ? 32'd1 : 32'd0;
            5'd9:  begin p = sy >>> x[4:0]; r = p[31:0]; end
            5'd10: r = {y[15:0], 16'h0};
            5'd12: r = ~(x | y);
            5'd13: begin p = sx * sy; h = p[63:32]; l = p[31:0]; r = l; end
            5'd14: begin p = {32'h0, x} * {32'h0, y}; h = p[63:32]; l = p[31:0]; r = l; end
            5'd15: begin
                if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
                else begin
                    q = sx / sy; rm = sx % sy;
                    p = q;  l = p[31:0];
                    p = rm; h = p[31:0];
                end
                r = l;
            end
            5'd16: begin
                if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
                else begin l = x / y; h = x % y; end
                r = l;
            end
            5'd17: r = h;
            5'd18: r = l;
            5'd19: begin h = x; r = x; end
            5'd20: begin l = x; r = x; end
            default: r = 32'h0;
        endcase
    endfunction

    // Issue one op, wait for its result, optionally hold it under backpressure
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int hold,
                          output logic [31:0] r, output logic z, output logic [31:0] h,
                          output logic [31:0] l, output int lat, output int bc);
        int w;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 5'($urandom);
        lat = 1; bc = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("in_ready_in_done", {63'h0, in_ready}, 64'h0);
        r = result; z = zero; h = hi; l = lo;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result_stable", result, r);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, res, hi, lo;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [31:0] r, h, l, mhi, mlo, eres, xa, xb;
        logic        z;
        int          lat, bc, elat, hold, cyc;
        logic [4:0]  o;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 0; a = 0; b = 0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = 0; a16 = 0; b16 = 0;

        tbl[0]  = '{5'd2,  32'hFFFF_FFFF, 32'h1,          32'h0,          32'h0,          32'h0};
        tbl[1]  = '{5'd9,  32'h24,        32'h8000_0000,  32'hF800_0000,  32'h0,          32'h0};
        tbl[2]  = '{5'd8,  32'hFFFF_FFFF, 32'h1,          32'h1,          32'h0,          32'h0};
        tbl[3]  = '{5'd7,  32'hFFFF_FFFF, 32'h1,          32'h0,          32'h0,          32'h0};
        tbl[4]  = '{5'd10, 32'h0,         32'h1234,       32'h1234_0000,  32'h0,          32'h0};
        tbl[5]  = '{5'd0,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000,  32'h0,          32'h0};
        tbl[6]  = '{5'd12, 32'h0,         32'h0,          32'hFFFF_FFFF,  32'h0,          32'h0};
        tbl[7]  = '{5'd6,  32'h0,         32'h1,          32'hFFFF_FFFF,  32'h0,          32'h0};
        tbl[8]  = '{5'd4,  32'h21,        32'h3,          32'h6,          32'h0,          32'h0};
        tbl[9]  = '{5'd19, 32'h55,        32'h7,          32'h55,         32'h55,         32'h0};
        tbl[10] = '{5'd20, 32'hAA,        32'h7,          32'hAA,         32'h55,         32'hAA};
        tbl[11] = '{5'd17, 32'h1,         32'h2,          32'h55,         32'h55,         32'hAA};
        tbl[12] = '{5'd11, 32'h5,         32'h6,          32'h0,          32'h55,         32'hAA};
        tbl[13] = '{5'd13, 32'hFFFF_FFFD, 32'h5,          32'hFFFF_FFF1,  32'hFFFF_FFFF,  32'hFFFF_FFF1};
        tbl[14] = '{5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h1,          32'hFFFF_FFFE,  32'h1};
        tbl[15] = '{5'd15, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  32'hFFFF_FFFD};
        tbl[16] = '{5'd16, 32'h9,         32'h0,          32'hFFFF_FFFF,  32'h9,          32'hFFFF_FFFF};
        tbl[17] = '{5'd15, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          32'h8000_0000};
        tbl[18] = '{5'd17, 32'h0,         32'h0,          32'h0,          32'h0,          32'h8000_0000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",  {63'h0, in_ready},  64'h1);
        chk("reset_out_valid", {63'h0, out_valid}, 64'h0);
        chk("reset_result",    result, 32'h0);
        chk("reset_zero",      {63'h0, zero},      64'h1);
        chk("reset_hi",        hi, 32'h0);
        chk("reset_lo",        lo, 32'h0);
        chk("reset_busy",      {63'h0, busy},      64'h0);

        // Directed vector table
        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, r, z, h, l, lat, bc);
            elat = (tbl[i].op >= 5'd13 && tbl[i].op <= 5'd16) ? 33 : 1;
            chk($sformatf("tbl%0d_result", i),  r, tbl[i].res);
            chk($sformatf("tbl%0d_zero", i),    {63'h0, z}, {63'h0, (tbl[i].res == 0)});
            chk($sformatf("tbl%0d_hi", i),      h, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i),      l, tbl[i].lo);
            chk($sformatf("tbl%0d_latency", i), lat, elat);
            chk($sformatf("tbl%0d_busy_cycles", i), bc, elat - 1);
        end
        mhi = 32'h0; mlo = 32'h8000_0000;

        // Backpressure: MFLO held for 5 cycles while a second op waits
        @(negedge clk);
        op = 5'd18; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 5'd2; a = 32'd1; b = 32'd2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {63'h0, out_valid}, 64'h1);
            chk("bp_result",    result, mlo);
            chk("bp_in_ready",  {63'h0, in_ready}, 64'h0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_exit_out_valid", {63'h0, out_valid}, 64'h0);
        chk("bp_exit_in_ready",  {63'h0, in_ready},  64'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_valid",  {63'h0, out_valid}, 64'h1);
        chk("bp_second_result", result, 32'd3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a divide after clearing HI/LO
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        op = 5'd15; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_before", {63'h0, busy}, 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", {63'h0, out_valid}, 64'h0);
        chk("abort_in_ready",  {63'h0, in_ready},  64'h1);
        chk("abort_busy",      {63'h0, busy},      64'h0);
        chk("abort_hi",        hi, 32'h0);
        chk("abort_lo",        lo, 32'h0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_result", {63'h0, out_valid}, 64'h0);
        mhi = 32'h0; mlo = 32'h0;

        // Randomized ops against the reference model
        for (int k = 0; k < 150; k++) begin
            o  = 5'($urandom_range(0, 31));
            xa = $urandom; xb = $urandom;
            case ($urandom_range(0, 9))
                0: xb = 32'h0;
                1: xb = 32'hFFFF_FFFF;
                2: xa = 32'h8000_0000;
                3: begin xa = 32'h8000_0000; xb = 32'hFFFF_FFFF; end
                4: xb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            hold = $urandom_range(0, 2);
            model(o, xa, xb, mhi, mlo, eres);
            elat = (o >= 5'd13 && o <= 5'd16) ? 33 : 1;
            run_op(o, xa, xb, hold, r, z, h, l, lat, bc);
            chk($sformatf("rnd%0d_op%0d_result", k, o), r, eres);
            chk($sformatf("rnd%0d_op%0d_zero", k, o), {63'h0, z}, {63'h0, (eres == 0)});
            chk($sformatf("rnd%0d_op%0d_hi", k, o), h, mhi);
            chk($sformatf("rnd%0d_op%0d_lo", k, o), l, mlo);
            chk($sformatf("rnd%0d_op%0d_latency", k, o), lat, elat);
        end

        // 16-bit build: MULTU 0xFFFF * 0xFFFF
        @(negedge clk);
        op16 = 5'd14; a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
        cyc = 1;
        while (!out_valid16 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w16_latency", cyc, 17);
        chk("w16_hi",      hi16, 16'hFFFE);
        chk("w16_lo",      lo16, 16'h0001);
        chk("w16_result",  result16, 16'h0001);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        chk("w16_idle", {63'h0, in_ready16}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the single-cycle CPU ALU. Adds registered, handshaked results and an iterative multiply/divide unit with architectural HI/LO registers. Sits in the EX stage: the pipeline issues one operation per handshake and stalls on in_ready low. Covers the existing logic, shift, compare and LUI operations, plus MIPS MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO.

Parameters:
WIDTH, 32, operand/result width; must be a power of two, >= 8
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  reset; synchronous and active-high
in_valid  in  1  operation offered
in_ready  out  1  unit can accept; high only in IDLE
op  in  5  operation code (see Behaviour)
a  in  WIDTH  operand A (shift amount for shifts)
b  in  WIDTH  operand B
out_valid  out  1  result held valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
zero  out  1  result == 0; registered with result
hi  out  WIDTH  architectural HI register
lo  out  WIDTH  architectural LO register
busy  out  1  multiply/divide iteration in progress

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, hi=0, lo=0, busy=0. Reset mid-operation abandons it; HI/LO are not updated.
- Accept when in_valid & in_ready. Operands and op are captured at accept and may change afterwards.
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> DONE for single-cycle ops.
  - IDLE -> MUL for 13/14; IDLE -> DIV for 15/16.
  - MUL/DIV -> DONE after exactly WIDTH iteration cycles.
  - DONE -> IDLE when out_ready. out_valid=1 only in DONE. result and zero are stable while out_valid & !out_ready.
- Latency from accept cycle to out_valid: 1 cycle for single-cycle ops, WIDTH+1 cycles for mul/div. No new accept in the cycle DONE exits (in_ready rises the next cycle).
- busy=1 in MUL/DIV only.
- Single-cycle ops:
  - 0 AND, 1 OR, 2 ADD (wraps, no overflow flag), 3 XOR.
  - 4 SLL: b << a[SHW-1:0]. 5 SRL: logical. 9 SRA: arithmetic, sign from b[WIDTH-1]. Only a[SHW-1:0] is used; upper bits are ignored.
  - 6 SUB (wraps).
  - 7 SLTU: unsigned a<b -> 1 else 0. 8 SLT: signed compare.
  - 10 LUI: {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 12 NOR.
  - 17 MFHI: result=hi. 18 MFLO: result=lo.
  - 19 MTHI: hi<=a, result=a. 20 MTLO: lo<=a, result=a. HI/LO are written on entry to DONE.
  - 11 and 21-31: result=0, zero=1, 1-cycle latency, HI/LO untouched.
- Multiply (13 MULT signed, 14 MULTU): radix-2 shift-add on magnitudes, one bit per cycle. Signed product is negated at the end if signs differ. {hi,lo} <= 2*WIDTH-bit product; result=low half.
- Divide (15 DIV signed, 16 DIVU): restoring, one quotient bit per cycle. lo<=quotient, hi<=remainder; result=quotient. Signed: quotient truncates toward zero, remainder takes the sign of the dividend.
- Divide by zero: lo<=all ones, hi<=a; same WIDTH+1 latency.
- Signed overflow (most-negative / -1): lo<=most-negative, hi<=0.
- hi/lo outputs change only on the clock edge entering DONE (or on rst).

Test Plan:
- Reset, then ADD a=0xFFFFFFFF, b=1 -> out_valid one cycle after accept, result=0, zero=1; in_ready=0 in DONE.
- SRA a=0x24 (shift 4), b=0x80000000 -> 0xF8000000. SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with same operands -> 0. LUI b=0x1234 -> 0x12340000.
- MULT a=-3, b=5 -> busy for 32 cycles, out_valid at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=9, b=0 -> lo=0xFFFFFFFF, hi=9. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- Backpressure: out_ready held low 5 cycles after MFLO -> result stable, in_ready=0, second in_valid not accepted until one cycle after out_ready.
- rst asserted at iteration 10 of DIV -> next cycle IDLE, out_valid=0, hi/lo keep pre-reset reset values (0); re-run with WIDTH=16: MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001, 17-cycle latency.
